// File: rtl/label_ram_arbiter_if.sv
// Bundle between the label RAM arbiter and its surroundings: display tap,
// host writer, RAM port and status. master = environment, slave = arbiter.
interface label_ram_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int QLG    = 2
);
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              vblank;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              wr_done;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_din;
   logic [QLG:0]      q_count;
   logic [1:0]        state;
   logic              overflow;
   logic              starve;

   modport master (
      output disp_req, disp_addr, vblank, wr_valid, wr_addr, wr_data,
      input  wr_ready, wr_done, ram_addr, ram_we, ram_din, q_count, state,
             overflow, starve
   );

   modport slave (
      input  disp_req, disp_addr, vblank, wr_valid, wr_addr, wr_data,
      output wr_ready, wr_done, ram_addr, ram_we, ram_din, q_count, state,
             overflow, starve
   );
endinterface

// File: rtl/label_ram_arbiter.sv
// Shares the single-port labels RAM: display reads always win, host writes
// are queued and drained in cycles where the display leaves the RAM idle.
module label_ram_arbiter #(
   parameter int          ADDR_W      = 8,
   parameter int          DATA_W      = 8,
   parameter int          QLG         = 2,
   parameter int          SYNC_VBLANK = 0,
   parameter logic [15:0] STARVE_MAX  = 16'd4096
) (
   input logic                clk,
   input logic                rst,
   label_ram_arbiter_if.slave bus
);
   localparam int           DEPTH   = 1 << QLG;
   localparam logic [QLG:0] DEPTH_C = (QLG+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DRAIN = 2'd2} state_t;

   logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W+DATA_W-1:0] head;
   logic [QLG-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [QLG:0]             count_q, count_d;
   state_t                   state_q, state_d;
   logic                     wr_done_q, wr_done_d;
   logic                     overflow_q, overflow_d;
   logic                     starve_q, starve_d;
   logic [15:0]              wait_q, wait_d;
   logic                     win, push, pop, full, nonempty;

   always_comb begin
      full       = (count_q == DEPTH_C);
      nonempty   = (count_q != '0);
      win        = !bus.disp_req && ((SYNC_VBLANK == 0) || bus.vblank);
      push       = bus.wr_valid && !full;
      // An empty queue cannot pop, so a fresh entry only becomes head next cycle.
      pop        = win && nonempty;
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
      wr_done_d  = pop;
      overflow_d = overflow_q || (bus.wr_valid && full);
      wait_d     = wait_q;
      if (pop)
         wait_d = '0;
      else if (nonempty && (wait_q != 16'hFFFF))
         wait_d = wait_q + 16'd1;
      starve_d   = starve_q || (wait_q > STARVE_MAX);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (nonempty) state_d = ARMED;
         ARMED:   if (win) state_d = DRAIN;
         DRAIN: begin
            if (count_d == '0)
               state_d = IDLE;
            else if (!win)
               state_d = ARMED;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= IDLE;
         wr_done_q  <= 1'b0;
         overflow_q <= 1'b0;
         starve_q   <= 1'b0;
         wait_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         wr_done_q  <= wr_done_d;
         overflow_q <= overflow_d;
         starve_q   <= starve_d;
         wait_q     <= wait_d;
      end
   end

   // Queue payload carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= {bus.wr_addr, bus.wr_data};
   end

   assign head         = mem_q[rd_ptr_q];
   assign bus.ram_we   = pop;
   assign bus.ram_addr = bus.disp_req ? bus.disp_addr : head[ADDR_W+DATA_W-1:DATA_W];
   assign bus.ram_din  = head[DATA_W-1:0];
   assign bus.wr_ready = !full;
   assign bus.wr_done  = wr_done_q;
   assign bus.q_count  = count_q;
   assign bus.state    = state_q;
   assign bus.overflow = overflow_q;
   assign bus.starve   = starve_q;
endmodule

// File: tb/tb_label_ram_arbiter.sv
// Drives two arbiters (free-running window and vblank-gated window) with the
// same stimulus and compares every cycle against a queue-based model.
module tb_label_ram_arbiter;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int QL = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   label_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .QLG(QL)) if0 ();
   label_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .QLG(QL)) if1 ();

   label_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .QLG(QL), .SYNC_VBLANK(0),
                       .STARVE_MAX(16'd4096)) u0 (.clk(clk), .rst(rst), .bus(if0));
   label_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .QLG(QL), .SYNC_VBLANK(1),
                       .STARVE_MAX(16'd8)) u1 (.clk(clk), .rst(rst), .bus(if1));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // stimulus currently applied
   logic       dreq = 1'b0, vb = 1'b0, wv = 1'b0;
   logic [7:0] da = '0, wa = '0, wd = '0;

   // reference model: pending writes as plain queues, one per instance
   logic [15:0] mq0[$];
   logic [15:0] mq1[$];
   int   m_wait[2];
   logic m_done[2], m_ovf[2], m_stv[2];
   int   m_state[2];
   int   smax[2] = '{4096, 8};
   int   sync[2] = '{0, 1};

   function automatic int q_size(input int k);
      return (k == 0) ? mq0.size() : mq1.size();
   endfunction

   function automatic logic [15:0] q_head(input int k);
      if (q_size(k) == 0) return 16'h0;
      return (k == 0) ? mq0[0] : mq1[0];
   endfunction

   function automatic logic m_win(input int k);
      return !dreq && (sync[k] == 0 || vb);
   endfunction

   task automatic m_reset();
      mq0.delete();
      mq1.delete();
      for (int k = 0; k < 2; k++) begin
         m_wait[k] = 0; m_done[k] = 0; m_ovf[k] = 0; m_stv[k] = 0; m_state[k] = 0;
      end
   endtask

   task automatic m_update(input int k);
      int   sz;
      logic w, pop, push;
      int   ns;
      sz   = q_size(k);
      w    = m_win(k);
      pop  = w && sz != 0;
      push = wv && sz < 4;
      if (wv && sz == 4) m_ovf[k] = 1;
      if (m_wait[k] > smax[k]) m_stv[k] = 1;
      if (pop) m_wait[k] = 0;
      else if (sz != 0 && m_wait[k] < 65535) m_wait[k]++;
      if (pop) begin
         if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
      end
      if (push) begin
         if (k == 0) mq0.push_back({wa, wd}); else mq1.push_back({wa, wd});
      end
      ns = m_state[k];
      case (m_state[k])
         0: if (sz != 0) ns = 1;
         1: if (w) ns = 2;
         default: if (q_size(k) == 0) ns = 0; else if (!w) ns = 1;
      endcase
      m_state[k] = ns;
      m_done[k]  = pop;
   endtask

   task automatic check_one(input int k, input logic rw, input logic [7:0] ra,
                            input logic [7:0] rd, input logic rdy, input logic done,
                            input logic [2:0] qc, input logic [1:0] st,
                            input logic ovf, input logic stv);
      string p;
      logic  we_e;
      p    = (k == 0) ? "u0" : "u1";
      we_e = m_win(k) && q_size(k) != 0;
      chk({p, ".ram_we"}, rw, we_e);
      if (dreq) chk({p, ".ram_addr_disp"}, ra, da);
      else if (q_size(k) != 0) chk({p, ".ram_addr_head"}, ra, q_head(k)[15:8]);
      if (we_e) chk({p, ".ram_din"}, rd, q_head(k)[7:0]);
      chk({p, ".wr_ready"}, rdy, q_size(k) != 4);
      chk({p, ".wr_done"}, done, m_done[k]);
      chk({p, ".q_count"}, qc, q_size(k));
      chk({p, ".state"}, st, m_state[k]);
      chk({p, ".overflow"}, ovf, m_ovf[k]);
      chk({p, ".starve"}, stv, m_stv[k]);
   endtask

   task automatic drive();
      if0.disp_req = dreq; if0.disp_addr = da; if0.vblank = vb;
      if0.wr_valid = wv;   if0.wr_addr   = wa; if0.wr_data = wd;
      if1.disp_req = dreq; if1.disp_addr = da; if1.vblank = vb;
      if1.wr_valid = wv;   if1.wr_addr   = wa; if1.wr_data = wd;
   endtask

   task automatic check_both();
      check_one(0, if0.ram_we, if0.ram_addr, if0.ram_din, if0.wr_ready, if0.wr_done,
                if0.q_count, if0.state, if0.overflow, if0.starve);
      check_one(1, if1.ram_we, if1.ram_addr, if1.ram_din, if1.wr_ready, if1.wr_done,
                if1.q_count, if1.state, if1.overflow, if1.starve);
   endtask

   task automatic step(input logic d, input logic [7:0] a, input logic v,
                       input logic w, input logic [7:0] adr, input logic [7:0] dat);
      @(negedge clk);
      dreq = d; da = a; vb = v; wv = w; wa = adr; wd = dat;
      drive();
      #1;
      check_both();
      @(posedge clk);
      m_update(0);
      m_update(1);
   endtask

   task automatic idle(input int n, input logic d, input logic v);
      for (int i = 0; i < n; i++) step(d, 8'h05, v, 1'b0, 8'h00, 8'h00);
   endtask

   // Reset asserted between edges with the window open and writes queued.
   task automatic async_reset();
      @(negedge clk);
      dreq = 1'b0; vb = 1'b1; wv = 1'b0;
      drive();
      #2 rst = 1'b1;
      #1;
      chk("rst.u0.q_count", if0.q_count, 0);
      chk("rst.u0.state", if0.state, 0);
      chk("rst.u0.ram_we", if0.ram_we, 0);
      chk("rst.u0.wr_ready", if0.wr_ready, 1);
      chk("rst.u0.wr_done", if0.wr_done, 0);
      chk("rst.u1.q_count", if1.q_count, 0);
      chk("rst.u1.ram_we", if1.ram_we, 0);
      chk("rst.u1.overflow", if1.overflow, 0);
      chk("rst.u1.starve", if1.starve, 0);
      m_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      m_reset();
      drive();
      #12;
      chk("init.u0.q_count", if0.q_count, 0);
      chk("init.u0.wr_ready", if0.wr_ready, 1);
      chk("init.u0.state", if0.state, 0);
      chk("init.u1.wr_done", if1.wr_done, 0);
      @(negedge clk);
      rst = 1'b0;

      // basic drain
      step(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 8'h41);
      idle(4, 1'b0, 1'b1);

      // display priority, then release
      for (int i = 0; i < 3; i++) step(1'b1, 8'h05, 1'b1, 1'b1, 8'h20 + 8'(i), 8'h60 + 8'(i));
      idle(3, 1'b1, 1'b1);
      idle(5, 1'b0, 1'b1);

      // overflow: five pushes while the window is closed
      for (int i = 0; i < 5; i++) step(1'b1, 8'h05, 1'b1, 1'b1, 8'h30 + 8'(i), 8'h70 + 8'(i));
      idle(6, 1'b0, 1'b1);

      async_reset();

      // interrupted drain
      for (int i = 0; i < 4; i++) step(1'b1, 8'h07, 1'b1, 1'b1, 8'h40 + 8'(i), 8'h80 + 8'(i));
      idle(2, 1'b0, 1'b1);
      idle(2, 1'b1, 1'b1);
      idle(4, 1'b0, 1'b1);

      // vblank gating and starvation on the gated instance
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 8'hAA);
      idle(14, 1'b0, 1'b0);
      idle(3, 1'b0, 1'b1);

      // reset mid-queue
      for (int i = 0; i < 3; i++) step(1'b1, 8'h09, 1'b0, 1'b1, 8'h90 + 8'(i), 8'hC0 + 8'(i));
      async_reset();
      idle(3, 1'b0, 1'b1);

      // randomized segments with varying display load and write rate
      for (int s = 0; s < 8; s++) begin
         int pd, pv, pw;
         pd = $urandom_range(0, 100);
         pv = $urandom_range(0, 100);
         pw = $urandom_range(0, 100);
         for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < pd, 8'($urandom), $urandom_range(0, 99) < pv,
                 $urandom_range(0, 99) < pw, 8'($urandom), 8'($urandom));
         if (s % 3 == 2) async_reset();
      end

      // long display burst starves the ungated instance
      async_reset();
      step(1'b1, 8'h11, 1'b1, 1'b1, 8'hEE, 8'h77);
      idle(4110, 1'b1, 1'b1);
      idle(4, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
